// File: rtl/x_alu_pkg.sv
// Shared widths, nibble type and 2-of-3 majority helper for the TMR nibble path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x_alu_pkg;

   localparam int NIBBLE_W = 4;
   localparam int COPIES   = 3;

   typedef logic [NIBBLE_W-1:0] nibble_t;

   // Bitwise 2-of-3 majority; a bit where all three copies differ resolves by the plain equation.
   function automatic nibble_t maj3(input nibble_t a, input nibble_t b, input nibble_t c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/x_alu_voter.sv
// tmr_voter4: bitwise 2-of-3 majority over three nibbles.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the output follows the inputs.
module tmr_voter4
   import x_alu_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_i,
   input  logic [NIBBLE_W-1:0] b_i,
   input  logic [NIBBLE_W-1:0] c_i,
   output logic [NIBBLE_W-1:0] v_o
);

   // Each bit position is voted independently of the others.
   always_comb begin
      v_o = maj3(a_i, b_i, c_i);
   end

endmodule

// File: rtl/x_alu.sv
// x_alu: decodes a TMR-coded nibble, stores it in three redundant registers, votes them out.
// Latency: 1 clock from nr_coded to result_uncoded; registers self-scrub on every edge.
// Backpressure: none; a new input is sampled on every rising clk edge.
module x_alu
   import x_alu_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [COPIES*NIBBLE_W-1:0]   nr_coded,
   output logic [NIBBLE_W-1:0]          result_uncoded
);

   nibble_t copy_a;
   nibble_t copy_b;
   nibble_t copy_c;
   nibble_t dec_v;

   nibble_t r0_d;
   nibble_t r1_d;
   nibble_t r2_d;

   // Three physically separate copies; the attributes stop synthesis merging them into one flop.
   (* keep = "true", preserve = "true", dont_touch = "true" *) nibble_t r0_q;
   (* keep = "true", preserve = "true", dont_touch = "true" *) nibble_t r1_q;
   (* keep = "true", preserve = "true", dont_touch = "true" *) nibble_t r2_q;

   // Split the coded word into its three copies: A is the top nibble, C the bottom.
   always_comb begin
      copy_a = nr_coded[11:8];
      copy_b = nr_coded[7:4];
      copy_c = nr_coded[3:0];
   end

   tmr_voter4 u_in_voter (
      .a_i (copy_a),
      .b_i (copy_b),
      .c_i (copy_c),
      .v_o (dec_v)
   );

   // Every register reloads the freshly decoded value, which also scrubs any single upset.
   always_comb begin
      r0_d = dec_v;
      r1_d = dec_v;
      r2_d = dec_v;
   end

   // Redundant copy 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r0_q <= '0;
      else      r0_q <= r0_d;
   end

   // Redundant copy 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r1_q <= '0;
      else      r1_q <= r1_d;
   end

   // Redundant copy 2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r2_q <= '0;
      else      r2_q <= r2_d;
   end

   // Output depends only on the registers, so nr_coded activity between edges cannot glitch it.
   tmr_voter4 u_out_voter (
      .a_i (r0_q),
      .b_i (r1_q),
      .c_i (r2_q),
      .v_o (result_uncoded)
   );

endmodule

// File: tb/tb_x_alu.sv
module tb_x_alu;

   logic        clk;
   logic        rst;
   logic [11:0] nr_coded;
   logic [3:0]  result_uncoded;

   int n_checks;
   int n_fail;

   logic [3:0] exp_q[$];

   x_alu dut (
      .clk            (clk),
      .rst            (rst),
      .nr_coded       (nr_coded),
      .result_uncoded (result_uncoded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench reference: per-bit vote by counting ones among the three copies.
   function automatic logic [3:0] ref_vote(input logic [11:0] c);
      logic [3:0] r;
      int         ones;
      for (int i = 0; i < 4; i++) begin
         ones = int'(c[8+i]) + int'(c[4+i]) + int'(c[i]);
         r[i] = (ones >= 2);
      end
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Drive a vector at the falling edge and record what must appear after the next rising edge.
   task automatic drive(input logic [11:0] c);
      @(negedge clk);
      nr_coded = c;
      exp_q.push_back(ref_vote(c));
   endtask

   // After the rising edge, compare the DUT output against the oldest pending expectation.
   task automatic collect(input string tag);
      logic [3:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %b, expected a queued value", tag, result_uncoded);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, result_uncoded, e);
      end
   endtask

   task automatic apply(input string tag, input logic [11:0] c);
      drive(c);
      collect(tag);
   endtask

   // Corrupt one register for a cycle; the voted output must not move and the next edge must repair it.
   task automatic upset(input int idx, input logic [3:0] voted);
      @(negedge clk);
      case (idx)
         0:       force dut.r0_q = 4'b1111;
         1:       force dut.r1_q = 4'b1111;
         default: force dut.r2_q = 4'b1111;
      endcase
      #1;
      check_eq("upset_hold_a", result_uncoded, voted);
      @(negedge clk);
      check_eq("upset_hold_b", result_uncoded, voted);
      case (idx)
         0:       release dut.r0_q;
         1:       release dut.r1_q;
         default: release dut.r2_q;
      endcase
      @(posedge clk);
      #1;
      case (idx)
         0:       check_eq("scrub_r0", dut.r0_q, voted);
         1:       check_eq("scrub_r1", dut.r1_q, voted);
         default: check_eq("scrub_r2", dut.r2_q, voted);
      endcase
      check_eq("upset_after", result_uncoded, voted);
   endtask

   // Guard against a stalled run.
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset held before any clock edge: output cleared regardless of input.
      rst      = 1'b0;
      nr_coded = 12'b1111_1111_1111;
      #2;
      check_eq("reset_pre_edge", result_uncoded, 4'b0000);
      @(posedge clk);
      #1;
      check_eq("reset_held_edge", result_uncoded, 4'b0000);

      // Clean input: first edge after release loads it, then it holds for 200 ns.
      @(negedge clk);
      nr_coded = 12'b0001_0001_0001;
      rst      = 1'b1;
      exp_q.push_back(4'b0001);
      collect("clean_first_edge");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("clean_hold", result_uncoded, 4'b0001);
      end

      // Single-copy errors.
      apply("single_err_c", 12'b0001_0001_0011);
      check_eq("single_err_c_const", result_uncoded, 4'b0001);
      apply("single_err_a", 12'b1111_0000_0000);
      check_eq("single_err_a_const", result_uncoded, 4'b0000);
      apply("single_err_mix", 12'b1010_1010_0101);
      check_eq("single_err_mix_const", result_uncoded, 4'b1010);

      // All three copies differ in some positions.
      apply("all_differ_0", 12'b0001_0010_0100);
      check_eq("all_differ_0_const", result_uncoded, 4'b0000);
      apply("all_differ_f", 12'b0111_1011_1101);
      check_eq("all_differ_f_const", result_uncoded, 4'b1111);

      // Latency: a mid-cycle change must not reach the output until the next edge.
      apply("lat_base", 12'b0001_0001_0001);
      #2;
      nr_coded = 12'b0011_0011_0011;
      #1;
      check_eq("lat_mid_cycle", result_uncoded, 4'b0001);
      @(negedge clk);
      check_eq("lat_before_edge", result_uncoded, 4'b0001);
      @(posedge clk);
      #1;
      check_eq("lat_after_edge", result_uncoded, 4'b0011);
      @(negedge clk);
      nr_coded = 12'b0101_0101_0101;
      check_eq("lat_hold", result_uncoded, 4'b0011);
      @(posedge clk);
      #1;
      check_eq("lat_next_edge", result_uncoded, 4'b0101);

      // Mid-operation asynchronous reset.
      apply("mid_rst_base", 12'b0001_0001_0001);
      #2;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_async", result_uncoded, 4'b0000);
      @(negedge clk);
      check_eq("mid_rst_held", result_uncoded, 4'b0000);
      rst = 1'b1;
      exp_q.push_back(4'b0001);
      #1;
      check_eq("mid_rst_release_no_edge", result_uncoded, 4'b0000);
      collect("mid_rst_reload");

      // Upset injection on each register in turn.
      apply("upset_base", 12'b1010_1010_1010);
      for (int i = 0; i < 3; i++) begin
         upset(i, 4'b1010);
      end

      // Randomised vectors, mostly with single-copy corruption.
      for (int i = 0; i < 24; i++) begin
         logic [3:0]  v;
         logic [11:0] c;
         v = 4'($urandom_range(0, 15));
         c = {v, v, v};
         c = c ^ (12'(1) << $urandom_range(0, 11));
         if (i % 4 == 3) c = 12'($urandom);
         drive(c);
         collect("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/x_alu.md
X_ALU -- requirements
Module: x_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst as the codebase does.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 nr_coded  input  12  triple-modular-redundant (TMR) coded nibble: copy A = [11:8], copy B = [7:4], copy C = [3:0].
REQ-005 result_uncoded  output  4  decoded, error-corrected nibble, driven from registered state.
REQ-006 The block SHALL have no parameters; all widths are fixed (3 copies x 4 bits).

Function
REQ-007 Input decode SHALL be a bitwise 2-of-3 majority over copies A, B and C: v[i] = (A[i]&B[i]) | (A[i]&C[i]) | (B[i]&C[i]) for i = 0..3.
REQ-008 Decode SHALL correct any error pattern in which, for each bit position, at most one copy disagrees; positions are independent.
REQ-009 When all three copies differ in a bit position, that bit SHALL resolve by the majority equation, with no special case.
REQ-010 Decoded value v SHALL be written, on every rising clk edge while rst is high, into three identical internal 4-bit state registers R0, R1 and R2.
REQ-011 result_uncoded SHALL be the bitwise 2-of-3 majority of R0, R1 and R2, as combinational logic from the registers only.
REQ-012 Latency SHALL be exactly 1 clock: a value applied before edge N appears on result_uncoded after edge N and holds until the next edge.
REQ-013 The block SHALL have no handshake and no enable; a new input is sampled on every edge.
REQ-014 A single upset in any one of R0, R1 or R2 SHALL NOT change result_uncoded, and SHALL be overwritten on the next edge (self-scrubbing).
REQ-015 The output SHALL be glitch-free with respect to nr_coded changes between edges; there is no combinational input-to-output path.

Reset
REQ-016 While rst = 0, R0, R1 and R2 SHALL be 4'b0000 immediately and asynchronously, so result_uncoded = 4'b0000.
REQ-017 Reset asserted mid-operation SHALL clear the output without waiting for a clock edge.
REQ-018 After rst returns to 1, the first rising edge SHALL load the decoded input.
REQ-019 Reset SHALL affect only the state registers; the decode logic is purely combinational.

Structure
REQ-020 A shared package SHALL hold the constants NIBBLE_W = 4 and COPIES = 3, plus a helper or typedef for the 4-bit nibble.
REQ-021 The majority function SHALL be one sub-module, tmr_voter4 (three 4-bit inputs, one 4-bit output).
REQ-022 x_alu SHALL instantiate tmr_voter4 twice: once for input decode and once for output voting.
REQ-023 The three state registers SHALL be kept distinct: no sharing, and synthesis keep/preserve attributes applied.

Verification
REQ-024 Reset: hold rst = 0 with any nr_coded -> result_uncoded = 4'b0000 before any clock edge.
REQ-025 Clean input: nr_coded = 12'b0001_0001_0001, release reset, 1 edge -> 4'b0001, held for a 200 ns run at a 10 ns clock.
REQ-026 Single-copy error: 12'b0001_0001_0011 -> 4'b0001; 12'b1111_0000_0000 -> 4'b0000; 12'b1010_1010_0101 -> 4'b1010, each after 1 edge.
REQ-027 All copies differ: 12'b0001_0010_0100 -> 4'b0000; 12'b0111_1011_1101 -> 4'b1111.
REQ-028 Latency: change nr_coded mid-cycle -> output unchanged until the next rising edge, then updates exactly once.
REQ-029 Mid-operation reset: output at 4'b0001, pull rst low between edges -> 4'b0000 immediately; release -> 4'b0001 after 1 edge.
REQ-030 Upset injection: force one of R0, R1 or R2 to 4'b1111 for one cycle -> result_uncoded stays at the voted value, and the register is restored after the next edge.
